// File: rtl/midi_note_parser.sv
// midi_note_parser: MIDI Note On/Off parser with running status, FWFT event FIFO and held-key bitmap.
// Define MIDI_CHANNEL_FILTER_EN to accept only note messages on channel CHANNEL.
module midi_note_parser #(
  parameter int FIFO_DEPTH = 8,
  parameter int KEY_OFFSET = 21,
  parameter int NUM_KEYS   = 88,
  parameter int CHANNEL    = 0
) (
  input  logic                clk_100mhz,
  input  logic                reset,
  input  logic [7:0]          byte_in,
  input  logic                byte_valid,
  output logic                event_valid,
  input  logic                event_ready,
  output logic [6:0]          event_key,
  output logic                event_on,
  output logic [6:0]          event_vel,
  output logic [NUM_KEYS-1:0] keys_down,
  output logic                overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef MIDI_CHANNEL_FILTER_EN
  localparam logic FILTER = 1'b1;
`else
  localparam logic FILTER = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, NOTE, VEL, SKIP} state_t;
  typedef struct packed {
    logic [6:0] key;
    logic       on;
    logic [6:0] vel;
  } evt_t;
  state_t        state, state_n;
  logic          type_on, type_on_n;
  logic [6:0]    note, note_n;
  logic          done, chan_ok, in_range, fire_on, push, pop, full, wr_en;
  logic          is_rt, is_sys, is_data;
  logic [6:0]    key;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  evt_t          mem [FIFO_DEPTH];
  evt_t          head;
  assign is_rt    = byte_in >= 8'hF8;
  assign is_sys   = byte_in[7:4] == 4'hF && !is_rt;
  assign is_data  = !byte_in[7];
  assign chan_ok  = !FILTER || byte_in[3:0] == 4'(CHANNEL);
  assign in_range = {1'b0, note} >= 8'(KEY_OFFSET) && {1'b0, note} < 8'(KEY_OFFSET + NUM_KEYS);
  assign key      = 7'({1'b0, note} - 8'(KEY_OFFSET));
  assign fire_on  = type_on && byte_in[6:0] != 7'd0;
  assign push     = done && in_range;
  assign full     = count == (AW+1)'(FIFO_DEPTH);
  assign pop      = event_valid && event_ready;
  assign wr_en    = push && (!full || pop);
  always_comb begin
    state_n   = state;
    type_on_n = type_on;
    note_n    = note;
    done      = 1'b0;
    if (byte_valid && !is_rt) begin
      if (is_sys) state_n = IDLE;
      else if (!is_data) begin
        state_n   = (byte_in[7:5] == 3'b100 && chan_ok) ? NOTE : SKIP;
        type_on_n = byte_in[4];
      end else if (state == NOTE) begin
        note_n  = byte_in[6:0];
        state_n = VEL;
      end else if (state == VEL) begin
        done    = 1'b1;
        state_n = NOTE;
      end
    end
  end
  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      state     <= IDLE;
      type_on   <= 1'b0;
      note      <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      keys_down <= '0;
      overflow  <= 1'b0;
    end else begin
      state   <= state_n;
      type_on <= type_on_n;
      note    <= note_n;
      if (push) keys_down[key] <= fire_on;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count    <= count + (AW+1)'(wr_en) - (AW+1)'(pop);
      overflow <= overflow || (push && full && !pop);
    end
  end
  always_ff @(posedge clk_100mhz)
    if (wr_en) mem[wr_ptr] <= '{key: key, on: fire_on, vel: fire_on ? byte_in[6:0] : 7'd0};
  // Head fields read as zero whenever the FIFO is empty, which also yields the reset values.
  assign head        = mem[rd_ptr];
  assign event_valid = count != '0;
  assign event_key   = event_valid ? head.key : 7'd0;
  assign event_on    = event_valid ? head.on : 1'b0;
  assign event_vel   = event_valid ? head.vel : 7'd0;
endmodule
